// File: rtl/ibr128_block_feeder.sv
// ibr128_block_feeder: packs 32-bit words into padded 128-bit blocks and hands them to the mode stage one at a time
module ibr128_block_feeder #(
    parameter bit PAD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      inWord,
    input  logic             inValid,
    input  logic             inLast,
    output logic             inReady,
    output logic             Enable,
    output logic             FB,
    output logic [127:0]     plainText,
    input  logic             cipherReady,
    output logic [CNT_W-1:0] blkCount,
    output logic             msgDone
);
    typedef enum logic [1:0] {FILL, PAD, ISSUE, WAIT} state_t;
    state_t state;
    logic [1:0] idx, nidx;
    logic [3:0][31:0] data, padded;
    logic first_flag, last_flag, cr_q, cr_rise;
    assign inReady = (state == FILL) && !Rst;
    assign cr_rise = cipherReady && !cr_q;
    assign nidx = ~idx;
    // element e holds slot 3-e; slots before idx keep their words, slot idx takes the pad marker
    for (genvar e = 0; e < 4; e++) begin : g_pad
        assign padded[e] = (2'(e) > nidx) ? data[e] : (2'(e) == nidx && PAD_EN) ? 32'h8000_0000 : 32'h0;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= FILL;
            idx        <= 2'd0;
            data       <= '0;
            Enable     <= 1'b0;
            FB         <= 1'b0;
            plainText  <= '0;
            blkCount   <= '0;
            msgDone    <= 1'b0;
            first_flag <= 1'b1;
            last_flag  <= 1'b0;
            cr_q       <= 1'b0;
        end else begin
            cr_q    <= cipherReady;
            msgDone <= 1'b0;
            if (msgDone) blkCount <= '0;
            case (state)
                FILL: if (inValid) begin
                    data[nidx] <= inWord;
                    idx        <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        last_flag <= inLast;
                        state     <= ISSUE;
                    end else if (inLast) begin
                        last_flag <= 1'b1;
                        state     <= PAD;
                    end
                end
                PAD: begin
                    data  <= padded;
                    state <= ISSUE;
                end
                ISSUE: begin
                    plainText <= data;
                    Enable    <= 1'b1;
                    FB        <= first_flag;
                    idx       <= 2'd0;
                    state     <= WAIT;
                end
                WAIT: if (cr_rise) begin
                    blkCount   <= blkCount + CNT_W'(1);
                    msgDone    <= last_flag;
                    first_flag <= last_flag;
                    last_flag  <= 1'b0;
                    Enable     <= 1'b0;
                    FB         <= 1'b0;
                    state      <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_ibr128_block_feeder.sv
// tb_ibr128_block_feeder: directed checks of block packing, padding, completion handshake and counter wrap
module tb_ibr128_block_feeder;
    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [31:0]  inWord = '0;
    logic         inValid = 1'b0;
    logic         inLast = 1'b0;
    logic         cipherReady = 1'b0;
    logic         rdy_p, en_p, fb_p, done_p;
    logic [127:0] pt_p;
    logic [1:0]   cnt_p;
    logic         rdy_z, en_z, fb_z, done_z;
    logic [127:0] pt_z;
    logic [15:0]  cnt_z;
    int n_tests = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    ibr128_block_feeder #(.PAD_EN(1'b1), .CNT_W(2)) u_pad (
        .Clk(Clk), .Rst(Rst), .inWord(inWord), .inValid(inValid), .inLast(inLast),
        .inReady(rdy_p), .Enable(en_p), .FB(fb_p), .plainText(pt_p),
        .cipherReady(cipherReady), .blkCount(cnt_p), .msgDone(done_p)
    );

    ibr128_block_feeder #(.PAD_EN(1'b0), .CNT_W(16)) u_zero (
        .Clk(Clk), .Rst(Rst), .inWord(inWord), .inValid(inValid), .inLast(inLast),
        .inReady(rdy_z), .Enable(en_z), .FB(fb_z), .plainText(pt_z),
        .cipherReady(cipherReady), .blkCount(cnt_z), .msgDone(done_z)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic last);
        inWord  = w;
        inLast  = last;
        inValid = 1'b1;
        for (int n = 0; n < 40 && !rdy_p; n++) begin
            @(posedge Clk); #1;
        end
        check("send_ready", rdy_p, 1'b1);
        @(posedge Clk); #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic wait_en();
        for (int n = 0; n < 40 && !en_p; n++) begin
            @(posedge Clk); #1;
        end
        check("enable_seen", en_p, 1'b1);
    endtask

    task automatic complete(input logic [1:0] exp_cnt, input logic exp_done);
        repeat (2) begin
            @(posedge Clk); #1;
        end
        check("held_enable", en_p, 1'b1);
        cipherReady = 1'b1;
        @(posedge Clk); #1;
        cipherReady = 1'b0;
        check("done_enable", en_p, 1'b0);
        check("done_fb", fb_p, 1'b0);
        check("done_count", cnt_p, exp_cnt);
        check("done_pulse", done_p, exp_done);
        check("done_ready", rdy_p, 1'b1);
        @(posedge Clk); #1;
        check("pulse_end", done_p, 1'b0);
        check("count_after", cnt_p, exp_done ? 2'd0 : exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(posedge Clk); #1;
        check("rst_enable", en_p, 1'b0);
        check("rst_fb", fb_p, 1'b0);
        check("rst_pt", pt_p, 128'h0);
        check("rst_count", cnt_p, 2'd0);
        check("rst_done", done_p, 1'b0);
        check("rst_ready", rdy_p, 1'b0);
        Rst = 1'b0;
        #1;
        check("fill_ready", rdy_p, 1'b1);

        // full 4-word message: ISSUE follows the last word directly
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        send(32'h3333_3333, 1'b0);
        send(32'h4444_4444, 1'b1);
        check("t1_issue_ready", rdy_p, 1'b0);
        check("t1_issue_en", en_p, 1'b0);
        @(posedge Clk); #1;
        check("t1_no_pad_en", en_p, 1'b1);
        check("t1_fb", fb_p, 1'b1);
        check("t1_pt", pt_p, 128'h11111111_22222222_33333333_44444444);
        complete(2'd1, 1'b1);

        // 6-word message spans two blocks, second padded
        for (int i = 0; i < 4; i++) send(32'hA000_0000 + 32'(i), 1'b0);
        wait_en();
        check("t2_b1_fb", fb_p, 1'b1);
        check("t2_b1_pt", pt_p, 128'hA0000000_A0000001_A0000002_A0000003);
        complete(2'd1, 1'b0);
        send(32'hA000_0004, 1'b0);
        send(32'hA000_0005, 1'b1);
        wait_en();
        check("t2_b2_fb", fb_p, 1'b0);
        check("t2_b2_pt", pt_p, 128'hA0000004_A0000005_80000000_00000000);
        check("t2_b2_pt_zero", pt_z, 128'hA0000004_A0000005_00000000_00000000);
        complete(2'd2, 1'b1);

        // single-word message
        send(32'hDEAD_BEEF, 1'b1);
        wait_en();
        check("t3_fb", fb_z, 1'b1);
        check("t3_pt_zero", pt_z, 128'hDEADBEEF_00000000_00000000_00000000);
        check("t3_pt_pad", pt_p, 128'hDEADBEEF_80000000_00000000_00000000);
        complete(2'd1, 1'b1);

        // upstream stays valid and cipherReady is already high when WAIT begins
        for (int i = 1; i <= 4; i++) send(32'(i), i == 4);
        inWord      = 32'hFFFF_FFFF;
        inValid     = 1'b1;
        cipherReady = 1'b1;
        repeat (4) begin
            @(posedge Clk); #1;
            check("t4_hold_ready", rdy_p, 1'b0);
            check("t4_hold_en", en_p, 1'b1);
        end
        check("t4_hold_count", cnt_p, 2'd0);
        check("t4_pt", pt_p, 128'h00000001_00000002_00000003_00000004);
        inValid     = 1'b0;
        cipherReady = 1'b0;
        @(posedge Clk); #1;
        check("t4_low_en", en_p, 1'b1);
        cipherReady = 1'b1;
        @(posedge Clk); #1;
        cipherReady = 1'b0;
        check("t4_done_en", en_p, 1'b0);
        check("t4_done_pulse", done_p, 1'b1);
        check("t4_done_count", cnt_p, 2'd1);
        @(posedge Clk); #1;
        check("t4_count_clear", cnt_p, 2'd0);

        // reset while the second block waits
        for (int i = 0; i < 4; i++) send(32'hB000_0000 + 32'(i), 1'b0);
        wait_en();
        complete(2'd1, 1'b0);
        for (int i = 4; i < 8; i++) send(32'hB000_0000 + 32'(i), 1'b0);
        wait_en();
        check("t5_b2_fb", fb_p, 1'b0);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        #1;
        check("t5_rst_en", en_p, 1'b0);
        check("t5_rst_count", cnt_p, 2'd0);
        check("t5_rst_ready", rdy_p, 1'b1);
        send(32'h5555_5555, 1'b1);
        wait_en();
        check("t5_new_fb", fb_p, 1'b1);
        check("t5_new_pt", pt_p, 128'h55555555_80000000_00000000_00000000);
        complete(2'd1, 1'b1);

        // 20-word message wraps the 2-bit counter
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 4; i++) send(32'h6000_0000 + 32'(b * 4 + i), b == 4 && i == 3);
            wait_en();
            check("t6_fb", fb_p, b == 0);
            check("t6_pt_w0", pt_p[127:96], 32'h6000_0000 + 32'(b * 4));
            if (b == 4) begin
                repeat (2) begin
                    @(posedge Clk); #1;
                end
                cipherReady = 1'b1;
                @(posedge Clk); #1;
                cipherReady = 1'b0;
                check("t6_last_count", cnt_p, 2'd1);
                check("t6_last_done", done_p, 1'b1);
                check("t6_wide_count", cnt_z, 16'd5);
                @(posedge Clk); #1;
                check("t6_count_clear", cnt_p, 2'd0);
            end else begin
                complete(2'(b + 1), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
